cordic_result_stage: RTL and testbench

//  Output stage directly downstream of the unrolled 21-bit CORDIC rotation pipeline.

---
 rtl/cordic_result_stage.sv | 172 +++++++++++++++++
 tb/tb_cordic_result_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_result_stage.sv
// -----------------------------------------------------------------------------
// cordic_result_stage
//
// Output stage behind an unrolled (non-stallable) 21-bit CORDIC rotation
// pipeline. A tag delay line carries each accepted sample's valid bit and
// negate flag alongside the fixed-latency pipeline. When the tag arrives with
// the final x word, x is sign-corrected and clamped to [-ONE, +ONE]. The result
// is then pushed into a small FIFO that feeds a valid/ready consumer port.
// Upstream flow control uses credits: a sample is only admitted when a FIFO
// slot is guaranteed for it.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   flush        synchronous clear of in-flight tags and buffered results
//   entry_valid  sample enters the CORDIC pipeline this cycle
//   entry_neg    1 = negate this sample's result
//   entry_ready  upstream may present a sample this cycle
//   cordic_x     signed final x word, PIPE_DEPTH cycles after entry
//   out_valid    out_data holds a result
//   out_ready    consumer accepts out_data
//   out_data     signed result, sign-extended to OUT_W
//   overflow_err sticky: a write hit a full FIFO
// -----------------------------------------------------------------------------
module cordic_result_stage #(
    parameter int PIPE_DEPTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAC       = 19,
    parameter int OUT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             entry_valid,
    input  logic             entry_neg,
    output logic             entry_ready,
    input  logic [20:0]      cordic_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             overflow_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(PIPE_DEPTH + 1);
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    localparam logic signed [21:0] C_POS_ONE = 22'(1 << FRAC);
    localparam logic signed [21:0] C_NEG_ONE = -C_POS_ONE;

    // Negate (in 22 bits so -2^20 is representable) and clamp to [-ONE, +ONE].
    // The clamp absorbs CORDIC gain overshoot as well as the negated -2^20 case.
    function automatic logic [20:0] fix_up(input logic [20:0] x, input logic neg);
        logic signed [21:0] ext;
        logic signed [21:0] v;
        ext = {x[20], x};
        if (neg) begin
            v = -ext;
        end else begin
            v = ext;
        end
        if (v > C_POS_ONE) begin
            fix_up = C_POS_ONE[20:0];
        end else if (v < C_NEG_ONE) begin
            fix_up = C_NEG_ONE[20:0];
        end else begin
            fix_up = v[20:0];
        end
    endfunction

    logic [PIPE_DEPTH-1:0] r_tag_v;
    logic [PIPE_DEPTH-1:0] r_tag_n;
    logic [IW-1:0]         r_inflight;
    logic [20:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic                  w_entry;
    logic                  w_tag_valid;
    logic                  w_tag_neg;
    logic [20:0]           w_fixed;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_ovf;
    logic [SW-1:0]         w_credit_sum;
    logic [20:0]           w_head;

    assign w_entry      = entry_valid & entry_ready;
    assign w_tag_valid  = r_tag_v[PIPE_DEPTH-1];
    assign w_tag_neg    = r_tag_n[PIPE_DEPTH-1];
    assign w_fixed      = fix_up(cordic_x, w_tag_neg);
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_pop        = out_valid & out_ready;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_wr         = w_tag_valid & (~w_full | w_pop);
    assign w_ovf        = w_tag_valid & w_full & ~w_pop;
    // Credits come from registered state only, so out_ready never reaches entry_ready.
    assign w_credit_sum = SW'(r_inflight) + SW'(r_count);
    assign w_head       = r_mem[r_rd_ptr];

    assign entry_ready  = (w_credit_sum < SW'(FIFO_DEPTH));
    assign out_valid    = (r_count != {CW{1'b0}});
    assign out_data     = {{(OUT_W-21){w_head[20]}}, w_head};
    assign overflow_err = r_overflow;

    // Tag delay line: shifts {entry, entry_neg} in step with the CORDIC pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_v <= {PIPE_DEPTH{1'b0}};
            r_tag_n <= {PIPE_DEPTH{1'b0}};
        end else if (flush) begin
            r_tag_v <= {PIPE_DEPTH{1'b0}};
            r_tag_n <= {PIPE_DEPTH{1'b0}};
        end else begin
            r_tag_v[0] <= w_entry;
            r_tag_n[0] <= entry_neg;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_n[i] <= r_tag_n[i-1];
            end
        end
    end

    // In-flight credit counter: up on accepted entry, down when its tag reaches the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= {IW{1'b0}};
        end else if (flush) begin
            r_inflight <= {IW{1'b0}};
        end else begin
            r_inflight <= r_inflight + IW'(w_entry) - IW'(w_tag_valid);
        end
    end

    // Result FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 21'd0;
            end
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_fixed;
                r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_result_stage.sv
module tb_cordic_result_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        entry_valid;
    logic        entry_neg;
    logic        entry_ready;
    logic [20:0] cordic_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        overflow_err;

    logic [20:0] tb_next_x;
    logic [20:0] tb_xp [4];
    logic [31:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_result_stage #(
        .PIPE_DEPTH(4), .FIFO_DEPTH(4), .FRAC(19), .OUT_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .entry_valid(entry_valid), .entry_neg(entry_neg), .entry_ready(entry_ready),
        .cordic_x(cordic_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow_err(overflow_err)
    );

    // Stand-in for the 4-stage CORDIC pipeline: x presented at entry emerges 4 cycles later.
    always @(posedge clk) begin
        tb_xp[0] <= tb_next_x;
        for (int i = 1; i < 4; i++) tb_xp[i] <= tb_xp[i-1];
    end
    assign cordic_x = tb_xp[3];

    // Reference: negate, clamp to +-2^19, sign-extend to 32 bits.
    function automatic logic [31:0] model(input logic [20:0] x, input logic neg);
        int v;
        v = int'(x);
        if (x[20]) v = v - 2097152;
        if (neg) v = -v;
        if (v > 524288) v = 524288;
        if (v < -524288) v = -524288;
        return 32'(v);
    endfunction

    // Single entry with out_ready=1; returns the first result seen (bounded wait).
    task automatic one_shot(input logic [20:0] x, input logic neg,
                            output logic [31:0] data, output logic found);
        @(negedge clk);
        entry_valid = 1'b1; tb_next_x = x; entry_neg = neg; out_ready = 1'b1;
        found = 1'b0; data = 32'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!found && out_valid) begin found = 1'b1; data = out_data; end
            entry_valid = 1'b0;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; entry_valid = 1'b0; entry_neg = 1'b0;
        out_ready = 1'b0; tb_next_x = 21'd0;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow_err); end
        total++; if (entry_ready !== 1'b1) begin bad++; $display("FAIL reset_entry_ready got=%0b want=1", entry_ready); end
        reset_n = 1'b1;
    endtask

    task automatic test_latency();
        logic early;
        early = 1'b0;
        @(negedge clk);
        entry_valid = 1'b1; tb_next_x = 21'h06A09A; entry_neg = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            entry_valid = 1'b0;
            if (k < 5 && out_valid !== 1'b0) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL latency_early got=out_valid_before_t5 want=none"); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_t5_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 32'h0006A09A) begin bad++; $display("FAIL latency_data got=%h want=0006a09a", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_pop got=%0b want=0", out_valid); end
    endtask

    task automatic test_fixup();
        logic [20:0] xs [6];
        logic        ns [6];
        logic [31:0] es [6];
        logic [31:0] d;
        logic        f;
        xs[0] = 21'h040000; ns[0] = 1'b1; es[0] = 32'hFFFC0000;
        xs[1] = 21'h080001; ns[1] = 1'b0; es[1] = 32'h00080000;
        xs[2] = 21'h100000; ns[2] = 1'b1; es[2] = 32'h00080000;
        xs[3] = 21'h17FFFF; ns[3] = 1'b0; es[3] = 32'hFFF80000;
        xs[4] = 21'h080000; ns[4] = 1'b1; es[4] = 32'hFFF80000;
        xs[5] = 21'h1C0000; ns[5] = 1'b1; es[5] = 32'h00040000;
        for (int i = 0; i < 6; i++) begin
            one_shot(xs[i], ns[i], d, f);
            total++;
            if (!f) begin bad++; $display("FAIL fixup_%0d_timeout got=no_output want=%h", i, es[i]); end
            else if (d !== es[i]) begin bad++; $display("FAIL fixup_%0d got=%h want=%h", i, d, es[i]); end
        end
    endtask

    task automatic test_credits();
        int acc;
        logic [31:0] w;
        acc = 0; exp_q.delete(); out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            entry_valid = 1'b1; tb_next_x = 21'(32'h1000 * (i + 1)); entry_neg = 1'b0;
            if (entry_ready) begin exp_q.push_back(32'h1000 * (i + 1)); acc++; end
        end
        @(negedge clk);
        entry_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (acc != 4) begin bad++; $display("FAIL credit_accepted got=%0d want=4", acc); end
        total++; if (entry_ready !== 1'b0) begin bad++; $display("FAIL credit_ready_full got=%0b want=0", entry_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL credit_out_valid got=%0b want=1", out_valid); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL credit_overflow got=%0b want=0", overflow_err); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL credit_extra got=%h want=none", out_data); end
                else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin bad++; $display("FAIL credit_data got=%h want=%h", out_data, w); end
                end
            end
            @(negedge clk);
            if (k == 0) begin
                out_ready = 1'b0;
                total++; if (entry_ready !== 1'b1) begin bad++; $display("FAIL credit_after_pop got=%0b want=1", entry_ready); end
                @(negedge clk);
                out_ready = 1'b1;
            end
        end
        out_ready = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL credit_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int n_acc, n_pop;
        logic [20:0] x;
        logic [31:0] w;
        n_acc = 0; n_pop = 0; exp_q.delete(); out_ready = 1'b1;
        for (int c = 0; c < 120 && (n_acc < 14 || exp_q.size() != 0); c++) begin
            @(negedge clk);
            if (out_valid) begin
                total++; n_pop++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra got=%h want=none", out_data); end
                else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin bad++; $display("FAIL stream_data_%0d got=%h want=%h", n_pop, out_data, w); end
                end
            end
            if (n_acc < 14) begin
                if (n_acc == 5) x = 21'h0FFFFF;
                else if (n_acc == 9) x = 21'h100000;
                else x = 21'(32'h1357 + n_acc * 32'h5A3C);
                entry_valid = 1'b1; tb_next_x = x; entry_neg = n_acc[0];
                if (entry_ready) begin exp_q.push_back(model(x, n_acc[0])); n_acc++; end
            end else begin
                entry_valid = 1'b0;
            end
        end
        entry_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (n_pop != 14) begin bad++; $display("FAIL stream_count got=%0d want=14", n_pop); end
    endtask

    task automatic test_flush_and_reset();
        logic late;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            entry_valid = 1'b1; tb_next_x = 21'(32'h2000 + i); entry_neg = 1'b0;
        end
        @(negedge clk); entry_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%0b want=1", out_valid); end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid); end
        total++; if (entry_ready !== 1'b1) begin bad++; $display("FAIL flush_entry_ready got=%0b want=1", entry_ready); end
        late = 1'b0;
        repeat (8) begin @(negedge clk); if (out_valid !== 1'b0) late = 1'b1; end
        total++; if (late) begin bad++; $display("FAIL flush_late_output got=out_valid want=none"); end

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            entry_valid = 1'b1; tb_next_x = 21'(32'h3000 + i); entry_neg = 1'b1;
        end
        @(negedge clk); entry_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL rst_mid_out_data got=%h want=0", out_data); end
        total++; if (entry_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_entry_ready got=%0b want=1", entry_ready); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL rst_mid_overflow got=%0b want=0", overflow_err); end
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        late = 1'b0;
        repeat (8) begin @(negedge clk); if (out_valid !== 1'b0) late = 1'b1; end
        total++; if (late) begin bad++; $display("FAIL rst_mid_late_output got=out_valid want=none"); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fixup();
        test_credits();
        test_back_to_back();
        test_flush_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
